// File: rtl/debounce_fsm_amisha.sv
// Switch debouncer: synchronizer, free-running sample tick, and a 4-state Moore FSM
// that moves the debounced level only after STABLE_TICKS consecutive agreeing samples.
module debounce_fsm_amisha #(
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_BITS    = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       sw_amisha,
  output logic       db_level_amisha,
  output logic       db_tick_amisha,
  output logic       busy_amisha,
  output logic [1:0] state_dbg_amisha
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(STABLE_TICKS);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TICK_BITS-1:0]   tick_q, tick_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   busy_q, busy_d;
  logic                   sync_s;
  logic                   m_tick;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_amisha};
  assign sync_s = sync_q[SYNC_STAGES-1];

  // Sample tick is free-running so qualification windows are not aligned to input edges.
  assign tick_d = tick_q + TICK_BITS'(1);
  assign m_tick = &tick_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (sync_s) begin
          state_d = WAIT1;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT1: begin
        if (!sync_s) begin
          state_d = ZERO;
        end else if (m_tick) begin
          if (cnt_q == CW'(1)) state_d = ONE;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      ONE: begin
        if (!sync_s) begin
          state_d = WAIT0;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT0: begin
        if (sync_s) begin
          state_d = ONE;
        end else if (m_tick) begin
          if (cnt_q == CW'(1)) state_d = ZERO;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = ZERO;
    endcase

    // Outputs are decoded from the next state so they register on the same edge.
    level_d = (state_d == ONE) || (state_d == WAIT0);
    busy_d  = (state_d == WAIT1) || (state_d == WAIT0);
    pulse_d = (state_q == WAIT1) && (state_d == ONE);
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      sync_q  <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      state_q <= ZERO;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign db_level_amisha  = level_q;
  assign db_tick_amisha   = pulse_q;
  assign busy_amisha      = busy_q;
  assign state_dbg_amisha = state_q;

endmodule

// File: tb/tb_debounce_fsm_amisha.sv
// Bench for debounce_fsm_amisha: directed scenarios plus random switch activity,
// output changes checked against a reference model through an expected-event queue.
module tb_debounce_fsm_amisha;

  localparam int SYNC_STAGES  = 2;
  localparam int TICK_BITS    = 3;
  localparam int STABLE_TICKS = 3;
  localparam int TICK_PERIOD  = 1 << TICK_BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic       db_level, db_tick, busy;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Each entry: {cycle tag, level, tick, busy}
  logic [34:0] exp_q[$];

  debounce_fsm_amisha #(
    .SYNC_STAGES (SYNC_STAGES),
    .TICK_BITS   (TICK_BITS),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk_amisha      (clk),
    .reset_amisha    (rst),
    .sw_amisha       (sw),
    .db_level_amisha (db_level),
    .db_tick_amisha  (db_tick),
    .busy_amisha     (busy),
    .state_dbg_amisha(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Level flips once the synced input has disagreed with it continuously and
  // STABLE_TICKS sample ticks have fallen strictly after the first disagreeing edge.
  bit          m_level, m_pend, m_pulse;
  int          m_start, m_n;
  bit          m_hist[$];
  logic [2:0]  m_last = 3'b000;

  always @(posedge clk or posedge rst) begin
    bit          s;
    logic [2:0]  vec;
    logic [31:0] tag;
    if (rst) begin
      if (m_last != 3'b000) begin
        tag = cyc;
        exp_q.push_back({tag, 3'b000});
      end
      m_level = 1'b0;
      m_pend  = 1'b0;
      m_pulse = 1'b0;
      m_n     = 0;
      m_start = 0;
      m_last  = 3'b000;
      m_hist.delete();
      repeat (SYNC_STAGES) m_hist.push_back(1'b0);
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(sw);
      m_pulse = 1'b0;
      if (s == m_level) begin
        m_pend = 1'b0;
      end else if (!m_pend) begin
        m_pend  = 1'b1;
        m_start = m_n;
      end else if ((m_n % TICK_PERIOD) == TICK_PERIOD - 1 &&
                   ((m_n + 1) / TICK_PERIOD - (m_start + 1) / TICK_PERIOD) == STABLE_TICKS) begin
        m_level = s;
        m_pend  = 1'b0;
        m_pulse = s;
      end
      m_n = m_n + 1;
      vec = {m_level, m_pulse, m_pend};
      if (vec != m_last) begin
        tag = cyc + 1;
        exp_q.push_back({tag, vec});
        m_last = vec;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [2:0] prev_dut = 3'b000;

  always @(negedge clk) begin
    logic [2:0]  v;
    logic [34:0] e;
    v = {db_level, db_tick, busy};
    if (v !== prev_dut) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got {lvl,tick,busy}=%b required no change", cyc, v);
      end else begin
        e = exp_q.pop_front();
        if (e[34:3] != cyc || e[2:0] !== v) begin
          errors++;
          $display("FAIL output_event got cyc=%0d {lvl,tick,busy}=%b required cyc=%0d %b",
                   cyc, v, e[34:3], e[2:0]);
        end
      end
      prev_dut = v;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic set_sw(input logic v);
    @(negedge clk);
    sw = v;
  endtask

  // Counts edges after the one that first samples the new input until db_level reaches target.
  task automatic measure(input logic target, output int lat, output logic tick_at, output logic saw_tick);
    lat      = -1;
    tick_at  = 1'b0;
    saw_tick = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (db_tick) saw_tick = 1'b1;
      if (db_level == target) begin
        lat     = i - 1;
        tick_at = db_tick;
        break;
      end
    end
  endtask

  task automatic assert_reset(input string name);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk(name, {db_level, db_tick, busy, state_dbg}, 0);
  endtask

  task automatic release_reset(input logic sw_val);
    @(negedge clk);
    sw  = sw_val;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   lat;
    logic tick_at, saw_tick, bad;
    int   t1, nf;

    rst = 1'b1;
    sw  = 1'b0;

    // Reset held with the switch toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sw = 1'(($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      chk("reset_outputs", {db_level, db_tick, busy, state_dbg}, 0);
    end
    release_reset(1'b0);
    repeat (100) @(posedge clk);
    #1;
    chk("idle_after_reset", {db_level, db_tick, busy, state_dbg}, 0);

    // Clean press
    repeat ($urandom_range(0, 7)) @(posedge clk);
    set_sw(1'b1);
    measure(1'b1, lat, tick_at, saw_tick);
    chk_range("press_latency", lat, 19, 26);
    chk("press_tick_same_edge", tick_at, 1);
    @(posedge clk);
    #1;
    chk("press_tick_one_cycle", db_tick, 0);
    repeat (35) @(posedge clk);

    // Release
    repeat ($urandom_range(0, 7)) @(posedge clk);
    set_sw(1'b0);
    measure(1'b0, lat, tick_at, saw_tick);
    chk_range("release_latency", lat, 19, 26);
    chk("release_no_tick", saw_tick, 0);
    repeat (35) @(posedge clk);

    // Bounce: toggle every 5 clocks for 40 clocks, then hold low
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sw = ((c / 5) % 2 == 0);
      if (db_level || db_tick) bad = 1'b1;
    end
    repeat (20) begin
      @(negedge clk);
      if (db_level || db_tick) bad = 1'b1;
    end
    chk("bounce_no_rise", bad, 0);
    chk("bounce_state_zero", state_dbg, 0);
    chk("bounce_busy_low", busy, 0);

    // Final-tick glitch: synced input drops on the qualifying tick edge
    set_sw(1'b1);
    for (int k = 0; k < 10 && !m_pend; k++) @(negedge clk);
    t1 = (m_start / TICK_PERIOD) * TICK_PERIOD + TICK_PERIOD - 1;
    if (t1 <= m_start) t1 += TICK_PERIOD;
    nf = t1 + TICK_PERIOD * (STABLE_TICKS - 1);
    for (int k = 0; k < 60 && m_n != nf - 2; k++) @(negedge clk);
    sw = 1'b0;
    for (int k = 0; k < 10 && m_n != nf; k++) @(negedge clk);
    chk("glitch_pre_state_wait1", state_dbg, 1);
    chk("glitch_pre_busy", busy, 1);
    @(posedge clk);
    #1;
    chk("glitch_state_zero", state_dbg, 0);
    chk("glitch_level", db_level, 0);
    chk("glitch_no_tick", db_tick, 0);
    repeat (10) @(posedge clk);

    // Mid-operation reset in WAIT1, then in ONE
    set_sw(1'b1);
    for (int k = 0; k < 10 && !busy; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("midop_in_wait1", state_dbg, 1);
    assert_reset("reset_in_wait1");
    repeat (2) @(posedge clk);
    release_reset(1'b1);
    measure(1'b1, lat, tick_at, saw_tick);
    chk_range("requal_after_wait1_reset", lat, 19, 26);
    chk("requal_tick", tick_at, 1);
    repeat (10) @(posedge clk);
    assert_reset("reset_in_one");
    repeat (2) @(posedge clk);
    release_reset(1'b1);
    measure(1'b1, lat, tick_at, saw_tick);
    chk_range("requal_after_one_reset", lat, 19, 26);
    repeat (10) @(posedge clk);

    // Random switch activity
    for (int seg = 0; seg < 30; seg++) begin
      @(negedge clk);
      sw = 1'(($urandom_range(0, 1)));
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk("final_level", db_level, sw);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
